// File: rtl/fsm_reinject_queue_pkg.sv
// Shared types for the FSM reinject queue slice.
// Entry layout carried from the receive-side TCP FSM back into the flow pipe.
package fsm_reinject_queue_pkg;

    localparam int FLOWID_W = 8;
    localparam int SEQ_W    = 32;
    localparam int FLAGS_W  = 8;
    localparam int WIN_W    = 16;

    typedef struct packed {
        logic [SEQ_W-1:0]   seq_num;
        logic [SEQ_W-1:0]   ack_num;
        logic [FLAGS_W-1:0] flags;
        logic [WIN_W-1:0]   win_size;
    } tcp_hdr_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] size;
    } payload_entry_t;

    typedef struct packed {
        tcp_hdr_t            tcp_hdr;
        logic [FLOWID_W-1:0] flowid;
        logic                payload_val;
        payload_entry_t      payload_entry;
    } fsm_reinject_queue_struct;

endpackage

// File: rtl/fsm_reinject_q_ptr_ctrl.sv
// Pointer bookkeeping for the reinject queue: fire decisions,
// full/empty/occupancy from registered pointers, sticky error.
module fsm_reinject_q_ptr_ctrl #(
    parameter  int DEPTH      = 8,
    localparam int LOG2_DEPTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enq_val,
    input  logic                  deq_val,
    output logic                  enq_fire,
    output logic                  deq_fire,
    output logic [LOG2_DEPTH-1:0] wr_idx,
    output logic [LOG2_DEPTH-1:0] rd_idx,
    output logic                  full,
    output logic                  empty,
    output logic [LOG2_DEPTH:0]   occupancy,
    output logic                  err
);

    localparam logic [LOG2_DEPTH:0] PTR_ONE = {{LOG2_DEPTH{1'b0}}, 1'b1};

    logic [LOG2_DEPTH:0] wr_ptr;
    logic [LOG2_DEPTH:0] rd_ptr;

    assign wr_idx    = wr_ptr[LOG2_DEPTH-1:0];
    assign rd_idx    = rd_ptr[LOG2_DEPTH-1:0];
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_idx == rd_idx) &&
                       (wr_ptr[LOG2_DEPTH] != rd_ptr[LOG2_DEPTH]);
    assign occupancy = wr_ptr - rd_ptr;
    assign enq_fire  = enq_val && !full;
    assign deq_fire  = deq_val && !empty;

    // Rejected requests (overflow or underflow) latch err until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            err    <= 1'b0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + PTR_ONE;
            if (deq_fire) rd_ptr <= rd_ptr + PTR_ONE;
            if ((enq_val && full) || (deq_val && empty)) err <= 1'b1;
        end
    end

endmodule

// File: rtl/fsm_reinject_queue.sv
// First-word fall-through FIFO feeding FSM reinjected packets
// to the established-pipe merger.
module fsm_reinject_queue
    import fsm_reinject_queue_pkg::*;
#(
    parameter  int DEPTH      = 8,
    localparam int LOG2_DEPTH = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fsm_reinject_q_enq_req_val,
    input  fsm_reinject_queue_struct fsm_reinject_q_enq_req_data,
    output logic                     fsm_reinject_q_full,
    input  logic                     merger_fsm_reinject_q_deq_req_val,
    output fsm_reinject_queue_struct fsm_reinject_q_merger_deq_resp_data,
    output logic                     fsm_reinject_q_merger_empty,
    output logic [LOG2_DEPTH:0]      fsm_reinject_q_occupancy,
    output logic                     fsm_reinject_q_err
);

    fsm_reinject_queue_struct mem [DEPTH];

    logic                  enq_fire;
    logic                  deq_fire;
    logic [LOG2_DEPTH-1:0] wr_idx;
    logic [LOG2_DEPTH-1:0] rd_idx;

    fsm_reinject_q_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .enq_val   (fsm_reinject_q_enq_req_val),
        .deq_val   (merger_fsm_reinject_q_deq_req_val),
        .enq_fire  (enq_fire),
        .deq_fire  (deq_fire),
        .wr_idx    (wr_idx),
        .rd_idx    (rd_idx),
        .full      (fsm_reinject_q_full),
        .empty     (fsm_reinject_q_merger_empty),
        .occupancy (fsm_reinject_q_occupancy),
        .err       (fsm_reinject_q_err)
    );

    // Storage carries no reset; stale slots are masked by the pointers.
    always_ff @(posedge clk) begin
        if (enq_fire) mem[wr_idx] <= fsm_reinject_q_enq_req_data;
    end

    assign fsm_reinject_q_merger_deq_resp_data = mem[rd_idx];

endmodule
